// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: APB3 bus between the bridge (master) and a single slave
interface apb_master_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;
    modport master (output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
    modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command stream to APB3 transfers with wait-state timeout
module apb_master_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    apb_master_bridge_if.master apb
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          accept, done, tout, last;
    assign cmd_ready   = (state == IDLE) && presetn;
    assign apb.psel    = state != IDLE;
    assign apb.penable = state == ACCESS;
    // pready wins over timeout on the same edge, so tout is only raised when pready is low
    always_comb begin
        accept  = cmd_valid && cmd_ready;
        last    = cnt == CW'(TIMEOUT - 1);
        done    = (state == ACCESS) && apb.pready;
        tout    = (state == ACCESS) && !apb.pready && last;
        state_n = state == IDLE  ? (accept ? SETUP : IDLE) :
                  state == SETUP ? ACCESS :
                  (done || tout) ? IDLE : ACCESS;
        cnt_n   = accept ? '0 :
                  ((state == ACCESS) && !apb.pready && !last) ? cnt + 1'b1 : cnt;
    end
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state       <= IDLE;
            cnt         <= '0;
            apb.pwrite  <= 1'b0;
            apb.paddr   <= '0;
            apb.pwdata  <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rsp_valid <= done || tout;
            if (accept) begin
                apb.pwrite <= cmd_write;
                apb.paddr  <= cmd_addr;
                apb.pwdata <= cmd_wdata;
            end
            if (done || tout) begin
                rsp_err     <= tout || apb.pslverr;
                rsp_timeout <= tout;
                rsp_rdata   <= (done && !apb.pwrite && !apb.pslverr) ? apb.prdata : '0;
            end
        end
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed vectors for the APB master bridge
module tb_apb_master_bridge;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    int            vectors = 0;
    int            miscompares = 0;
    always #5 pclk = ~pclk;
    apb_master_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) apb ();
    apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .apb(apb)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    // waits = ACCESS cycles with pready low before it rises; waits >= TO forces a timeout
    task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int waits, input logic slverr, input logic [DW-1:0] rdata,
                        input logic [DW-1:0] exp_rdata, input logic exp_err, input logic exp_to);
        int edges;
        edges = (waits + 1 < TO) ? waits + 1 : TO;
        @(negedge pclk);
        check("idle_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        apb.pready = 1'b0; apb.pslverr = 1'b1; apb.prdata = 32'hBAD0BAD0;
        @(negedge pclk);
        cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ~addr; cmd_wdata = ~wdata;
        check("setup_psel", apb.psel, 1);
        check("setup_penable", apb.penable, 0);
        check("setup_cmd_ready", cmd_ready, 0);
        for (int k = 1; k <= edges; k++) begin
            @(negedge pclk);
            check("acc_psel", apb.psel, 1);
            check("acc_penable", apb.penable, 1);
            check("acc_paddr", apb.paddr, addr);
            check("acc_pwdata", apb.pwdata, wdata);
            check("acc_pwrite", apb.pwrite, wr);
            check("acc_rsp_valid", rsp_valid, 0);
            if (k == waits + 1) begin
                apb.pready = 1'b1; apb.pslverr = slverr; apb.prdata = rdata;
            end
        end
        @(negedge pclk);
        apb.pready = 1'b0; apb.pslverr = 1'b0;
        check("rsp_valid", rsp_valid, 1);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_err", rsp_err, exp_err);
        check("rsp_timeout", rsp_timeout, exp_to);
        check("rsp_psel", apb.psel, 0);
        check("rsp_cmd_ready", cmd_ready, 1);
        @(negedge pclk);
        check("post_rsp_valid", rsp_valid, 0);
        check("post_psel", apb.psel, 0);
        check("post_rdata_hold", rsp_rdata, exp_rdata);
    endtask
    initial begin
        apb.pready = 1'b0; apb.pslverr = 1'b0; apb.prdata = '0;
        #12;
        check("rst_psel", apb.psel, 0);
        check("rst_penable", apb.penable, 0);
        check("rst_pwrite", apb.pwrite, 0);
        check("rst_paddr", apb.paddr, 0);
        check("rst_pwdata", apb.pwdata, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        @(negedge pclk);
        presetn = 1'b1;
        xfer(1'b1, 32'h05, 32'hDEADBEEF, 0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        xfer(1'b0, 32'h05, 32'h0, 0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0);
        xfer(1'b1, 32'h100, 32'hA5A5_5A5A, 4, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        xfer(1'b0, 32'h40, 32'h0, 0, 1'b1, 32'h12345678, 32'h0, 1'b1, 1'b0);
        xfer(1'b0, 32'h80, 32'h0, 100, 1'b0, 32'h55, 32'h0, 1'b1, 1'b1);
        xfer(1'b0, 32'h84, 32'h0, TO - 1, 1'b0, 32'hCAFE0001, 32'hCAFE0001, 1'b0, 1'b0);
        xfer(1'b0, 32'h88, 32'h0, 2, 1'b0, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 1'b0);
        // back-to-back writes with cmd_valid held and pready tied high
        apb.pready = 1'b1; apb.pslverr = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge pclk);
            cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = AW'(j); cmd_wdata = DW'(j) + 32'h100;
            check("b2b_cmd_ready", cmd_ready, 1);
            check("b2b_gap_psel", apb.psel, 0);
            check("b2b_rsp_valid", rsp_valid, j > 0);
            @(negedge pclk);
            check("b2b_setup_psel", apb.psel, 1);
            check("b2b_setup_penable", apb.penable, 0);
            @(negedge pclk);
            check("b2b_acc_penable", apb.penable, 1);
            check("b2b_acc_paddr", apb.paddr, j);
            check("b2b_acc_pwdata", apb.pwdata, j + 32'h100);
        end
        @(negedge pclk);
        cmd_valid = 1'b0;
        check("b2b_last_rsp", rsp_valid, 1);
        check("b2b_last_err", rsp_err, 0);
        @(negedge pclk);
        check("b2b_end_rsp", rsp_valid, 0);
        check("b2b_end_psel", apb.psel, 0);
        // asynchronous reset while in ACCESS
        apb.pready = 1'b0;
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h200;
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        check("mid_penable", apb.penable, 1);
        #2 presetn = 1'b0;
        #1;
        check("mid_rst_psel", apb.psel, 0);
        check("mid_rst_penable", apb.penable, 0);
        check("mid_rst_cmd_ready", cmd_ready, 0);
        @(negedge pclk);
        check("mid_rst_rsp", rsp_valid, 0);
        presetn = 1'b1;
        @(negedge pclk);
        check("after_rst_cmd_ready", cmd_ready, 1);
        check("after_rst_rsp", rsp_valid, 0);
        check("after_rst_psel", apb.psel, 0);
        xfer(1'b0, 32'h300, 32'h0, 1, 1'b0, 32'h600DCAFE, 32'h600DCAFE, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
